// File: rtl/mem_access.sv
// rtl/mem_access.sv - MIPS memory-stage responder: load/store over a req/ack data RAM, pipeline pause, write-back
// Optional build macro: MEM_ALIGN_CHECK_EN (reject misaligned requests with a one-cycle misalign_err pulse)
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_flag,
  input  logic              mem_write_flag,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic              write_reg_en,
  input  logic [4:0]        write_reg_addr,
  input  logic [DATA_W-1:0] alu_result,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              pause_req_mem,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              req;
  logic              misaligned;
  logic              accept;
  logic              pause_c;
  logic [4:0]        dest_q, dest_d;
  logic              ram_req_d, ram_we_d, wb_en_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_d, wb_data_d;
  logic [4:0]        wb_addr_d;

  // Both flags set is treated as a store: ram_we follows mem_write_flag alone.
  assign req = mem_read_flag | mem_write_flag;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misaligned   = req & (mem_addr[1:0] != 2'b00);
  assign misalign_err = misalign_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign accept = req & ~misaligned;

  // Stall is combinational so decode freezes in the same cycle the request is seen; never during reset.
  assign pause_req_mem = rst & pause_c;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      dest_q    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ram_req   <= ram_req_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      wb_en     <= wb_en_d;
      wb_addr   <= wb_addr_d;
      wb_data   <= wb_data_d;
      dest_q    <= dest_d;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next-state: DONE lasts one cycle so the still-presented instruction is not re-issued
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (ram_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; RAM-side signals hold stable until ack
  always_comb begin
    pause_c     = 1'b0;
    ram_req_d   = ram_req;
    ram_we_d    = ram_we;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    wb_en_d     = wb_en;
    wb_addr_d   = wb_addr;
    wb_data_d   = wb_data;
    dest_d      = dest_q;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          pause_c     = 1'b1;
          ram_req_d   = 1'b1;
          ram_we_d    = mem_write_flag;
          ram_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
          ram_wdata_d = mem_write_data;
          dest_d      = write_reg_addr;
          wb_en_d     = 1'b0;
        end else if (misaligned) begin
          wb_en_d     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          misalign_d  = 1'b1;
`endif
        end else begin
          wb_en_d     = write_reg_en;
          wb_addr_d   = write_reg_addr;
          wb_data_d   = alu_result;
        end
      end
      BUSY: begin
        pause_c = 1'b1;
        if (ram_ack) begin
          ram_req_d = 1'b0;
          if (!ram_we) begin
            wb_en_d   = 1'b1;
            wb_addr_d = dest_q;
            wb_data_d = ram_rdata;
          end else begin
            wb_en_d   = 1'b0;
          end
        end
      end
      DONE: begin
        wb_en_d = 1'b0;
      end
      default: begin
        wb_en_d   = 1'b0;
        ram_req_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a transaction-level model
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_flag, mem_write_flag;
  logic [31:0] mem_addr, mem_write_data, alu_result;
  logic        write_reg_en;
  logic [4:0]  write_reg_addr;
  logic        ram_req, ram_we, ram_ack;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pause_req_mem, misalign_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference memory (updated from the stimulus) and the RAM device (updated from DUT bus traffic)
  logic [31:0] ref_mem [0:63];
  logic [31:0] ram_dev [0:63];

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .write_reg_en(write_reg_en), .write_reg_addr(write_reg_addr),
    .alu_result(alu_result),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pause_req_mem(pause_req_mem), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive_nop();
    mem_read_flag  = 1'b0;
    mem_write_flag = 1'b0;
    write_reg_en   = 1'b0;
  endtask

  // One instruction from decode, held until the stage finishes with it; wt = RAM wait cycles before ack
  task automatic do_op(input bit rd, input bit wr, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] dest,
                       input logic [31:0] alu, input int wt);
    bit          is_req, is_st, mis;
    logic [31:0] exp_rd, aligned;
    is_req  = rd | wr;
    is_st   = wr;
    aligned = {addr[31:2], 2'b00};
    exp_rd  = '0;
    mis     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = is_req && (addr[1:0] != 2'b00);
`endif
    @(negedge clk);
    mem_read_flag = rd; mem_write_flag = wr; mem_addr = addr; mem_write_data = wdata;
    write_reg_en = wen; write_reg_addr = dest; alu_result = alu;
    #1 check("pause_first", pause_req_mem, is_req && !mis);
    if (!is_req) begin
      @(negedge clk);
      drive_nop();
      #1;
      check("pt_wb_en", wb_en, wen);
      check("pt_wb_addr", wb_addr, dest);
      check("pt_wb_data", wb_data, alu);
      check("pt_ram_req", ram_req, 0);
      check("pt_pause", pause_req_mem, 0);
    end else if (mis) begin
      @(negedge clk);
      drive_nop();
      #1;
      check("mis_err", misalign_err, 1);
      check("mis_ram_req", ram_req, 0);
      check("mis_wb_en", wb_en, 0);
      check("mis_pause", pause_req_mem, 0);
      @(negedge clk);
      #1 check("mis_err_pulse", misalign_err, 0);
    end else begin
      if (is_st) ref_mem[addr[7:2]] = wdata;
      else       exp_rd = ref_mem[addr[7:2]];
      for (int i = 0; i <= wt; i++) begin
        @(negedge clk);
        check("busy_ram_req", ram_req, 1);
        check("busy_ram_we", ram_we, is_st);
        check("busy_ram_addr", ram_addr, aligned);
        check("busy_ram_wdata", ram_wdata, wdata);
        check("busy_wb_en", wb_en, 0);
        check("busy_pause", pause_req_mem, 1);
        if (i == wt) begin
          ram_ack = 1'b1;
          if (ram_we) begin
            ram_dev[ram_addr[7:2]] = ram_wdata;
            ram_rdata = $urandom;
          end else begin
            ram_rdata = ram_dev[ram_addr[7:2]];
          end
        end
      end
      @(negedge clk);
      ram_ack = 1'b0;
      ram_rdata = $urandom;
      #1;
      check("done_ram_req", ram_req, 0);
      check("done_wb_en", wb_en, !is_st);
      if (!is_st) begin
        check("done_wb_addr", wb_addr, dest);
        check("done_wb_data", wb_data, exp_rd);
      end
      check("done_pause", pause_req_mem, 0);
      check("done_misalign", misalign_err, 0);
      drive_nop();
      @(negedge clk);
      #1;
      check("after_wb_en", wb_en, 0);
      check("after_pause", pause_req_mem, 0);
      check("after_ram_req", ram_req, 0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'hA500_0000 | i;
      ram_dev[i] = 32'hA500_0000 | i;
    end
    rst = 1'b0;
    drive_nop();
    mem_addr = '0; mem_write_data = '0; write_reg_addr = '0; alu_result = '0;
    ram_ack = 1'b0; ram_rdata = '0;

    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_pause", pause_req_mem, 0);
    check("rst_misalign", misalign_err, 0);
    rst = 1'b1;

    // Directed cases
    ram_dev[32'h100 >> 2 & 63] = 32'hDEADBEEF;
    ref_mem[32'h100 >> 2 & 63] = 32'hDEADBEEF;
    do_op(1, 0, 1, 32'h100, 32'h0, 5'd5, 32'h0, 3);
    do_op(0, 1, 0, 32'h40, 32'h12345678, 5'd0, 32'h0, 0);
    do_op(0, 0, 1, 32'h0, 32'h0, 5'd3, 32'd7, 0);
    do_op(1, 1, 1, 32'h44, 32'hCAFEF00D, 5'd9, 32'h0, 1);
    do_op(1, 0, 1, 32'h44, 32'h0, 5'd9, 32'h0, 2);
    do_op(1, 0, 1, 32'h102, 32'h0, 5'd6, 32'h0, 0);

    // Reset during BUSY, late ack afterwards
    @(negedge clk);
    mem_read_flag = 1'b1; mem_addr = 32'h80; write_reg_en = 1'b1; write_reg_addr = 5'd4;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_nop();
    @(negedge clk);
    #1;
    check("rstbusy_ram_req", ram_req, 0);
    check("rstbusy_pause", pause_req_mem, 0);
    check("rstbusy_wb_en", wb_en, 0);
    rst = 1'b1;
    ram_ack = 1'b1;
    ram_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    ram_ack = 1'b0;
    #1;
    check("lateack_wb_en", wb_en, 0);
    check("lateack_ram_req", ram_req, 0);
    do_op(0, 0, 1, 32'h0, 32'h0, 5'd17, 32'h5555AAAA, 0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 255);
`ifdef MEM_ALIGN_CHECK_EN
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
`endif
      case (kind)
        0: do_op(0, 0, 1'($urandom), a, $urandom, 5'($urandom), $urandom, 0);
        1: do_op(1, 0, 1, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 4));
        2: do_op(0, 1, 0, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 4));
        default: do_op(1, 1, 1, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 4));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
